sample_resolve: RTL and testbench
=================================

SAMPLE_RESOLVE -- requirements
Module: sample_resolve

Interface
REQ-001 SHALL have parameter SIGFIG, default rast_params::SIGFIG, bits per color channel.
REQ-002 SHALL have parameter COLORS, default rast_params::COLORS, color channel count.
REQ-003 SHALL have parameter NUM_SAMPLES, default rast_params::NUM_SAMPLES, samples per pixel; power of two, 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_color  input  COLORS*SIGFIG  color substituted for missed samples.
REQ-007 SHALL have port in_valid  input  1  sample beat valid.
REQ-008 SHALL have port in_ready  output  1  sample beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_hit  input  1  sample covered by primitive.
REQ-010 SHALL have port in_color  input  COLORS*SIGFIG  sample color, unsigned.
REQ-011 SHALL have port in_last  input  1  asserted with sample index NUM_SAMPLES-1.
REQ-012 SHALL have port out_valid  output  1  resolved pixel valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts pixel.
REQ-014 SHALL have port out_color  output  COLORS*SIGFIG  resolved color.
REQ-015 SHALL have port out_mask  output  NUM_SAMPLES  coverage mask, bit i = hit of sample i.
REQ-016 SHALL have port err_framing  output  1  one-cycle pulse on sample-count/in_last mismatch.

Function
REQ-017 SHALL implement states ACCUM and HOLD; ACCUM accepts beats, HOLD presents a resolved pixel.
REQ-018 In ACCUM, in_ready SHALL be 1; in HOLD, in_ready SHALL equal out_ready (accepted beat starts the next pixel in the same cycle the held pixel drains).
REQ-019 Per accepted beat, each channel accumulator SHALL add in_color if in_hit else clear_color; accumulator width SIGFIG+log2(NUM_SAMPLES), no overflow possible.
REQ-020 Sample index counter (log2(NUM_SAMPLES) bits, min 1) SHALL increment per accepted beat and wrap to 0 after NUM_SAMPLES-1.
REQ-021 out_mask bit at current index SHALL capture in_hit per accepted beat.
REQ-022 On accepting the beat with index NUM_SAMPLES-1, SHALL register out_color = accumulator sum >> log2(NUM_SAMPLES) (truncate), latch out_mask, clear accumulators, go to HOLD.
REQ-023 Latency: out_valid SHALL assert the cycle after the final sample beat is accepted.
REQ-024 out_valid SHALL be 1 exactly in HOLD; out_color/out_mask SHALL stay stable while out_valid && !out_ready.
REQ-025 HOLD -> ACCUM on out_ready unless a new pixel's final beat is accepted that same cycle (only possible for NUM_SAMPLES=1), which stays in HOLD with new data.
REQ-026 If in_last disagrees with index==NUM_SAMPLES-1 on an accepted beat, err_framing SHALL pulse next cycle; resolve is driven by the counter, not in_last.
REQ-027 NUM_SAMPLES=1 SHALL pass the sample (or clear_color) through with one cycle latency.

Reset
REQ-028 On rst_n low, SHALL asynchronously enter ACCUM, zero counter, accumulators, out_color, out_mask; out_valid=0, err_framing=0.
REQ-029 Reset mid-pixel SHALL discard partial accumulation; first beat after release is sample 0.

Structure
REQ-030 Shared package rast_params SHALL hold NUM_SAMPLES, SIGFIG, COLORS and a new RESOLVE_SHIFT = $clog2(NUM_SAMPLES) constant and resolve state typedef.
REQ-031 SHALL instantiate one sub-module resolve_accum (per-channel adder/accumulator, generated COLORS times).

Verification
REQ-032 NUM_SAMPLES=4, 4 hits color (100,200,300) -> one cycle later out_color (100,200,300), out_mask 4'b1111.
REQ-033 NUM_SAMPLES=4, hits on samples 0,2 color 400, clear_color 0 -> out_color 200 all channels, out_mask 4'b0101.
REQ-034 out_ready held 0 for 5 cycles after out_valid, next pixel streamed -> output stable, in_ready=0, no beat lost; second pixel emerges after drain.
REQ-035 in_last asserted on sample 1 of 4 -> err_framing pulse one cycle; pixel still resolves after fourth beat.
REQ-036 rst_n dropped after 2 of 4 beats -> all outputs 0 immediately; next 4 beats resolve with no residue.
REQ-037 NUM_SAMPLES=1, back-to-back beats with out_ready=1 -> one pixel per cycle, in_ready never drops.

Source files
------------

// File: rtl/rast_params.sv
// Shared rasterizer parameters and the resolve state type.
package rast_params;

    localparam int SIGFIG        = 12;
    localparam int COLORS        = 3;
    localparam int NUM_SAMPLES   = 4;
    localparam int RESOLVE_SHIFT = $clog2(NUM_SAMPLES);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } resolve_state_t;

endpackage

// File: rtl/resolve_accum.sv
// One color channel of the resolver: sums hit colors or the clear color per sample.
module resolve_accum #(
    parameter int SIGFIG = 12,
    parameter int ACC_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_beat,
    input  logic              i_final,
    input  logic              i_hit,
    input  logic [SIGFIG-1:0] i_color,
    input  logic [SIGFIG-1:0] i_clear_color,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W-1:0]  r_acc;
    logic [SIGFIG-1:0] w_addend;

    assign w_addend = i_hit ? i_color : i_clear_color;
    assign o_sum    = r_acc + ACC_W'(w_addend);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_beat) begin
            r_acc <= i_final ? '0 : o_sum;
        end
    end

endmodule

// File: rtl/sample_resolve.sv
// Multisample resolve: averages NUM_SAMPLES sample beats into one pixel with coverage mask.
module sample_resolve #(
    parameter int SIGFIG      = rast_params::SIGFIG,
    parameter int COLORS      = rast_params::COLORS,
    parameter int NUM_SAMPLES = rast_params::NUM_SAMPLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLORS*SIGFIG-1:0] clear_color,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_hit,
    input  logic [COLORS*SIGFIG-1:0] in_color,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COLORS*SIGFIG-1:0] out_color,
    output logic [NUM_SAMPLES-1:0]   out_mask,
    output logic                     err_framing
);

    import rast_params::*;

    localparam int SHIFT = $clog2(NUM_SAMPLES);
    localparam int CNT_W = (SHIFT > 0) ? SHIFT : 1;
    localparam int ACC_W = SIGFIG + SHIFT;

    resolve_state_t             r_state;
    logic [CNT_W-1:0]           r_idx;
    logic [NUM_SAMPLES-1:0]     r_mask_part;
    logic [COLORS*SIGFIG-1:0]   r_out_color;
    logic [NUM_SAMPLES-1:0]     r_out_mask;
    logic                       r_err;

    logic                       w_in_ready;
    logic                       w_beat;
    logic                       w_final;
    logic [NUM_SAMPLES-1:0]     w_mask_next;
    logic [COLORS-1:0][ACC_W-1:0] w_sum;
    logic [COLORS*SIGFIG-1:0]   w_resolved;

    // A held pixel draining this cycle frees the input for the next pixel's beat.
    assign w_in_ready = (r_state == ACCUM) || out_ready;
    assign w_beat     = in_valid && w_in_ready;
    assign w_final    = (r_idx == CNT_W'(NUM_SAMPLES - 1));

    // NOTE: default first, then override, so the combinational block cannot infer a latch.
    always_comb begin
        w_mask_next        = r_mask_part;
        w_mask_next[r_idx] = in_hit;
    end

    for (genvar g = 0; g < COLORS; g++) begin : g_chan
        resolve_accum #(
            .SIGFIG (SIGFIG),
            .ACC_W  (ACC_W)
        ) u_accum (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_beat        (w_beat),
            .i_final       (w_final),
            .i_hit         (in_hit),
            .i_color       (in_color[g*SIGFIG +: SIGFIG]),
            .i_clear_color (clear_color[g*SIGFIG +: SIGFIG]),
            .o_sum         (w_sum[g])
        );
        // Top SIGFIG bits of the sum are the truncated average.
        assign w_resolved[g*SIGFIG +: SIGFIG] = w_sum[g][ACC_W-1 -: SIGFIG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_idx       <= '0;
            r_mask_part <= '0;
            r_out_color <= '0;
            r_out_mask  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_beat && (in_last != w_final);
            if (w_beat) begin
                r_idx       <= w_final ? '0 : r_idx + 1'b1;
                r_mask_part <= w_final ? '0 : w_mask_next;
            end
            if (w_beat && w_final) begin
                r_state     <= HOLD;
                r_out_color <= w_resolved;
                r_out_mask  <= w_mask_next;
            end else if (r_state == HOLD && out_ready) begin
                r_state <= ACCUM;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == HOLD);
    assign out_color   = r_out_color;
    assign out_mask    = r_out_mask;
    assign err_framing = r_err;

endmodule

// File: tb/tb_sample_resolve.sv
// Directed bench for sample_resolve: a 4-sample instance and a 1-sample pass-through instance.
module tb_sample_resolve;

    localparam int SF = 12;
    localparam int CL = 3;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [CL*SF-1:0] clear_color, in_color, out_color;
    logic             in_valid, in_ready, in_hit, in_last;
    logic             out_valid, out_ready, err_framing;
    logic [NS-1:0]    out_mask;

    logic [CL*SF-1:0] clear_color_1, in_color_1, out_color_1;
    logic             in_valid_1, in_ready_1, in_hit_1, in_last_1;
    logic             out_valid_1, out_ready_1, err_framing_1;
    logic [0:0]       out_mask_1;

    int total = 0;
    int bad   = 0;

    sample_resolve #(.SIGFIG(SF), .COLORS(CL), .NUM_SAMPLES(NS)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clear_color(clear_color),
        .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit),
        .in_color(in_color), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_color(out_color), .out_mask(out_mask),
        .err_framing(err_framing)
    );

    sample_resolve #(.SIGFIG(SF), .COLORS(CL), .NUM_SAMPLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear_color(clear_color_1),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_hit(in_hit_1),
        .in_color(in_color_1), .in_last(in_last_1), .out_valid(out_valid_1),
        .out_ready(out_ready_1), .out_color(out_color_1), .out_mask(out_mask_1),
        .err_framing(err_framing_1)
    );

    function automatic logic [CL*SF-1:0] rgb(input logic [SF-1:0] v);
        return {v, v, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic hit, input logic [CL*SF-1:0] color, input logic last);
        in_valid = 1'b1;
        in_hit   = hit;
        in_color = color;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic       v1_hit [4];
    logic [11:0] v1_col [4];
    logic [11:0] v1_exp [4];

    initial begin
        rst_n       = 1'b0;
        clear_color = '0;
        in_valid    = 1'b0;
        in_hit      = 1'b0;
        in_color    = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        clear_color_1 = rgb(12'd7);
        in_valid_1  = 1'b0;
        in_hit_1    = 1'b0;
        in_color_1  = '0;
        in_last_1   = 1'b1;
        out_ready_1 = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_color", 64'(out_color), 64'd0);
        check("rst_out_mask",  64'(out_mask),  64'd0);
        check("rst_err",       64'(err_framing), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full coverage, distinct channel colors
        beat(1'b1, {12'd300, 12'd200, 12'd100}, 1'b0);
        beat(1'b1, {12'd300, 12'd200, 12'd100}, 1'b0);
        beat(1'b1, {12'd300, 12'd200, 12'd100}, 1'b0);
        check("px1_not_early", 64'(out_valid), 64'd0);
        beat(1'b1, {12'd300, 12'd200, 12'd100}, 1'b1);
        check("px1_valid", 64'(out_valid), 64'd1);
        check("px1_color", 64'(out_color), 64'({12'd300, 12'd200, 12'd100}));
        check("px1_mask",  64'(out_mask),  64'b1111);
        check("px1_err",   64'(err_framing), 64'd0);
        @(posedge clk);
        #1;
        check("px1_drained", 64'(out_valid), 64'd0);

        // Hits on samples 0 and 2, clear color 0
        beat(1'b1, rgb(12'd400), 1'b0);
        beat(1'b0, rgb(12'd999), 1'b0);
        beat(1'b1, rgb(12'd400), 1'b0);
        beat(1'b0, rgb(12'd999), 1'b1);
        check("px2_color", 64'(out_color), 64'(rgb(12'd200)));
        check("px2_mask",  64'(out_mask),  64'b0101);
        @(posedge clk);
        #1;

        // Nonzero clear color fills missed samples: (100+3*40)/4 = 55
        clear_color = rgb(12'd40);
        beat(1'b1, rgb(12'd100), 1'b0);
        beat(1'b0, rgb(12'd555), 1'b0);
        beat(1'b0, rgb(12'd555), 1'b0);
        beat(1'b0, rgb(12'd555), 1'b1);
        check("px3_color", 64'(out_color), 64'(rgb(12'd55)));
        check("px3_mask",  64'(out_mask),  64'b0001);
        @(posedge clk);
        #1;

        // Truncating average: 7/4 = 1
        clear_color = '0;
        beat(1'b1, rgb(12'd1), 1'b0);
        beat(1'b1, rgb(12'd2), 1'b0);
        beat(1'b1, rgb(12'd2), 1'b0);
        beat(1'b1, rgb(12'd2), 1'b1);
        check("px4_trunc", 64'(out_color), 64'(rgb(12'd1)));
        @(posedge clk);
        #1;

        // Backpressure: held pixel stays stable, pending beat not lost
        out_ready = 1'b0;
        beat(1'b1, rgb(12'd10), 1'b0);
        beat(1'b1, rgb(12'd10), 1'b0);
        beat(1'b1, rgb(12'd10), 1'b0);
        beat(1'b1, rgb(12'd10), 1'b1);
        in_valid = 1'b1;
        in_hit   = 1'b1;
        in_color = rgb(12'd20);
        in_last  = 1'b0;
        check("bp_in_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_color",    64'(out_color), 64'(rgb(12'd10)));
            check("bp_in_ready", 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_drain_valid", 64'(out_valid), 64'd0);
        check("bp_drain_ready", 64'(in_ready),  64'd1);
        beat(1'b1, rgb(12'd40), 1'b0);
        beat(1'b1, rgb(12'd60), 1'b0);
        beat(1'b1, rgb(12'd80), 1'b1);
        check("bp_px2_valid", 64'(out_valid), 64'd1);
        check("bp_px2_color", 64'(out_color), 64'(rgb(12'd50)));
        check("bp_px2_mask",  64'(out_mask),  64'b1111);
        @(posedge clk);
        #1;

        // Early in_last on sample 1: one-cycle framing pulse, resolve still on count
        beat(1'b1, rgb(12'd4), 1'b0);
        check("fr_err_s0", 64'(err_framing), 64'd0);
        beat(1'b1, rgb(12'd4), 1'b1);
        check("fr_err_s1", 64'(err_framing), 64'd1);
        check("fr_no_early", 64'(out_valid), 64'd0);
        beat(1'b0, rgb(12'd4), 1'b0);
        check("fr_err_s2", 64'(err_framing), 64'd0);
        beat(1'b1, rgb(12'd4), 1'b1);
        check("fr_err_s3", 64'(err_framing), 64'd0);
        check("fr_valid",  64'(out_valid), 64'd1);
        check("fr_color",  64'(out_color), 64'(rgb(12'd3)));
        check("fr_mask",   64'(out_mask),  64'b1011);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-pixel discards partial sums
        beat(1'b1, rgb(12'd500), 1'b0);
        beat(1'b1, rgb(12'd500), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_color", 64'(out_color), 64'd0);
        check("mr_out_mask",  64'(out_mask),  64'd0);
        check("mr_err",       64'(err_framing), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(1'b1, rgb(12'd8), 1'b0);
        beat(1'b1, rgb(12'd8), 1'b0);
        beat(1'b1, rgb(12'd8), 1'b0);
        check("mr_not_early", 64'(out_valid), 64'd0);
        beat(1'b1, rgb(12'd8), 1'b1);
        check("mr_valid", 64'(out_valid), 64'd1);
        check("mr_color", 64'(out_color), 64'(rgb(12'd8)));
        check("mr_mask",  64'(out_mask),  64'b1111);

        // Single-sample instance: back-to-back pass-through
        v1_hit = '{1'b1, 1'b0, 1'b1, 1'b1};
        v1_col = '{12'd11, 12'd99, 12'd33, 12'd44};
        v1_exp = '{12'd11, 12'd7,  12'd33, 12'd44};
        for (int i = 0; i < 4; i++) begin
            in_valid_1 = 1'b1;
            in_hit_1   = v1_hit[i];
            in_color_1 = rgb(v1_col[i]);
            check("ns1_in_ready", 64'(in_ready_1), 64'd1);
            @(posedge clk);
            #1;
            check("ns1_valid", 64'(out_valid_1), 64'd1);
            check("ns1_color", 64'(out_color_1), 64'(rgb(v1_exp[i])));
            check("ns1_mask",  64'(out_mask_1),  64'(v1_hit[i]));
            check("ns1_err",   64'(err_framing_1), 64'd0);
        end
        in_valid_1 = 1'b0;
        @(posedge clk);
        #1;
        check("ns1_drained", 64'(out_valid_1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
